// File: rtl/axi4lite_stream_loader.sv
// Loads memstream weights: one stream entry per beat becomes WORDS 32-bit AXI4-Lite writes, LSW first, one write in flight.
// Build with LOADER_READBACK_EN to read each word back after its B response and flag any mismatch in error.
module axi4lite_stream_loader #(
    parameter int MEM_DEPTH          = 13824,
    parameter int MEM_WIDTH          = 32,
    parameter int AXILITE_ADDR_WIDTH = 2 + $clog2(MEM_DEPTH * (1 << $clog2((MEM_WIDTH + 31) / 32)))
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [((MEM_WIDTH+7)/8)*8-1:0]      s_axis_tdata,
    output logic                                awvalid,
    input  logic                                awready,
    output logic [AXILITE_ADDR_WIDTH-1:0]       awaddr,
    output logic [2:0]                          awprot,
    output logic                                wvalid,
    input  logic                                wready,
    output logic [31:0]                         wdata,
    output logic [3:0]                          wstrb,
    input  logic                                bvalid,
    output logic                                bready,
    input  logic [1:0]                          bresp,
    output logic                                arvalid,
    input  logic                                arready,
    output logic [AXILITE_ADDR_WIDTH-1:0]       araddr,
    output logic [2:0]                          arprot,
    input  logic                                rvalid,
    output logic                                rready,
    input  logic [31:0]                         rdata,
    input  logic [1:0]                          rresp
);
    localparam int AW     = AXILITE_ADDR_WIDTH;
    localparam int WORDS  = (MEM_WIDTH + 31) / 32;
    localparam int STRIDE = 1 << $clog2(WORDS);
    localparam int EB     = WORDS * 32;
    localparam int EW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [EB-1:0] ENTRY_MASK = {EB{1'b1}} >> (EB - MEM_WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GET   = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
`ifdef LOADER_READBACK_EN
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
`endif
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]             r_state;
    logic [EW-1:0]          r_e;
    logic [KW-1:0]          r_k;
    logic [WORDS-1:0][31:0] r_entry;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   w_last_word;
    logic                   w_last_entry;
    logic                   w_adv;
    logic [2:0]             w_adv_state;
    logic                   w_aw_done;
    logic                   w_w_done;
    logic [AW-1:0]          w_addr;
    logic [31:0]            w_wdata;

    assign w_last_word  = (r_k == KW'(WORDS - 1));
    assign w_last_entry = (r_e == EW'(MEM_DEPTH - 1));
    assign w_adv_state  = !w_last_word ? S_WR : (!w_last_entry ? S_GET : S_DONE);
    assign w_addr       = (AW'(r_e) * AW'(STRIDE) + AW'(r_k)) << 2;
    assign w_wdata      = r_entry[r_k];
    assign w_aw_done    = !r_awvalid || awready;
    assign w_w_done     = !r_wvalid || wready;

`ifdef LOADER_READBACK_EN
    logic r_arvalid;
    assign w_adv   = (r_state == S_RDATA) && rvalid;
    assign arvalid = r_arvalid;
    assign araddr  = w_addr;
    assign rready  = (r_state == S_RDATA);
`else
    logic w_unused_rd;
    assign w_adv       = (r_state == S_RESP) && bvalid;
    assign arvalid     = 1'b0;
    assign araddr      = '0;
    assign rready      = 1'b0;
    assign w_unused_rd = arready ^ rvalid ^ (^rdata) ^ (^rresp);
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_e       <= '0;
            r_k       <= '0;
            r_entry   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
`ifdef LOADER_READBACK_EN
            r_arvalid <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_GET;
                    r_error <= 1'b0;
                    r_e     <= '0;
                    r_busy  <= 1'b1;
                end
                S_GET: if (s_axis_tvalid) begin
                    r_entry   <= EB'(s_axis_tdata) & ENTRY_MASK;
                    r_k       <= '0;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_state   <= S_WR;
                end
                // AW and W retire independently; leave only once both have gone.
                S_WR: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) r_state <= S_RESP;
                end
                S_RESP: if (bvalid) begin
                    if (bresp != 2'b00) r_error <= 1'b1;
`ifdef LOADER_READBACK_EN
                    r_arvalid <= 1'b1;
                    r_state   <= S_RD;
`endif
                end
`ifdef LOADER_READBACK_EN
                S_RD: if (arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_RDATA;
                end
                S_RDATA: if (rvalid && (rresp != 2'b00 || rdata != w_wdata)) r_error <= 1'b1;
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Completion of a word: next sub-word, next entry, or finish.
            if (w_adv) begin
                r_state <= w_adv_state;
                if (!w_last_word) begin
                    r_k       <= r_k + 1'b1;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else if (!w_last_entry) begin
                    r_e <= r_e + 1'b1;
                end else begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign s_axis_tready = (r_state == S_GET);
    assign awvalid       = r_awvalid;
    assign awaddr        = w_addr;
    assign awprot        = 3'b000;
    assign wvalid        = r_wvalid;
    assign wdata         = w_wdata;
    assign wstrb         = 4'hF;
    assign bready        = (r_state == S_RESP);
    assign arprot        = 3'b000;
endmodule

// File: tb/tb_axi4lite_stream_loader.sv
// Bench for axi4lite_stream_loader with MEM_WIDTH=72 (3 words, stride 4) and MEM_DEPTH=2.
module tb_axi4lite_stream_loader;
    localparam int AW = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          start;
    logic          busy, done, error;
    logic          s_axis_tvalid, s_axis_tready;
    logic [71:0]   s_axis_tdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;

    axi4lite_stream_loader #(.MEM_DEPTH(2), .MEM_WIDTH(72)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done), .error(error),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [71:0] data; logic [2:0][31:0] w; } vec_t;
    typedef struct { int ia; int ib; int aw_lat; int w_lat; int berr; int starve; logic exp_err; } load_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

    vec_t  tab [4];
    load_t loads [6];
    wr_t   sbq [$];
    logic [31:0] mem [logic [AW-1:0]];

    int n_chk = 0;
    int n_fail = 0;
    int aw_lat = 0, w_lat = 0, berr = -1, wr_cnt = 0, bcnt = 0, split = 0, prot_err = 0;
    logic corrupt = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave: configurable AW/W ready latency, B response with optional SLVERR, scoreboard pop per B.
    initial begin : slave
        int aw_wait, w_wait;
        logic aw_cap, w_cap, b_pend, awv_q, awr_q, wv_q, wr_q, ar_cap, r_pend;
        logic [AW-1:0] cap_addr, awa_q, rd_addr;
        logic [31:0] cap_data, wd_q;
        wr_t exp;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_wait = 0; w_wait = 0; aw_cap = 0; w_cap = 0; b_pend = 0; ar_cap = 0; r_pend = 0;
        awv_q = 0; awr_q = 0; wv_q = 0; wr_q = 0; cap_addr = 0; cap_data = 0; awa_q = 0; wd_q = 0; rd_addr = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cap = 0; w_cap = 0; b_pend = 0; ar_cap = 0; r_pend = 0;
                aw_wait = 0; w_wait = 0; awv_q = 0; awr_q = 0; wv_q = 0; wr_q = 0;
            end else begin
                if (awv_q && !awr_q && (!awvalid || awaddr != awa_q)) prot_err++;
                if (wv_q && !wr_q && (!wvalid || wdata != wd_q)) prot_err++;
                if (awvalid != wvalid) split++;
                if (b_pend) begin
                    bvalid = 0; b_pend = 0; bcnt++;
                    chk("sb_has_entry", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        exp = sbq.pop_front();
                        chk("awaddr", cap_addr, exp.addr);
                        chk("wdata", cap_data, exp.data);
                    end
                end else if (!bvalid && aw_cap && w_cap) begin
                    bvalid = 1; bresp = (wr_cnt == berr) ? 2'b10 : 2'b00;
                    wr_cnt++; aw_cap = 0; w_cap = 0; mem[cap_addr] = cap_data;
                end
                if (bvalid && !b_pend) b_pend = bready;
                awv_q = awvalid; awa_q = awaddr; wv_q = wvalid; wd_q = wdata;
                if (awready) awready = 0;
                else if (awvalid && !aw_cap) begin
                    if (aw_wait >= aw_lat) begin awready = 1; aw_cap = 1; cap_addr = awaddr; aw_wait = 0; end
                    else aw_wait++;
                end
                if (wready) wready = 0;
                else if (wvalid && !w_cap) begin
                    if (w_wait >= w_lat) begin wready = 1; w_cap = 1; cap_data = wdata; w_wait = 0; end
                    else w_wait++;
                end
                awr_q = awready; wr_q = wready;
`ifdef LOADER_READBACK_EN
                if (r_pend) begin rvalid = 0; r_pend = 0; end
                else if (ar_cap && !rvalid) begin
                    rvalid = 1; rresp = 2'b00; rdata = mem[rd_addr] ^ {31'b0, corrupt}; ar_cap = 0;
                end
                if (rvalid && !r_pend) r_pend = rready;
                if (arready) begin arready = 0; ar_cap = 1; end
                else if (arvalid) begin arready = 1; rd_addr = araddr; end
`endif
            end
        end
    end

    task automatic send_entry(input int idx, input int slot);
        int guard;
        wr_t e;
        s_axis_tvalid = 1; s_axis_tdata = tab[idx].data;
        for (int k = 0; k < 3; k++) begin
            e.addr = AW'(slot * 16 + k * 4);
            e.data = tab[idx].w[k];
            sbq.push_back(e);
        end
        guard = 0;
        while (!s_axis_tready && guard < 300) begin @(negedge aclk); guard++; end
        chk("stream_accept", s_axis_tready, 1);
        @(negedge aclk);
        s_axis_tvalid = 0; s_axis_tdata = '0;
    endtask

    task automatic run_load(input load_t L);
        int dcnt, guard, act;
        aw_lat = L.aw_lat; w_lat = L.w_lat; berr = L.berr;
        wr_cnt = 0; bcnt = 0; split = 0; prot_err = 0;
        start = 1; @(negedge aclk); start = 0;
        chk("busy_on_start", busy, 1);
        chk("error_cleared", error, 0);
        send_entry(L.ia, 0);
        if (L.starve > 0) begin
            guard = 0;
            while (!s_axis_tready && guard < 300) begin @(negedge aclk); guard++; end
            act = 0;
            for (int i = 0; i < L.starve; i++) begin
                start = (i == 2);
                @(negedge aclk);
                if (awvalid || wvalid) act++;
            end
            start = 0;
            chk("starved_no_aw", act, 0);
            chk("busy_while_starved", busy, 1);
        end
        send_entry(L.ib, 1);
        guard = 0;
        while (!done && guard < 500) begin @(negedge aclk); guard++; end
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dcnt++;
            @(negedge aclk);
        end
        chk("done_pulses", dcnt, 1);
        chk("b_count", bcnt, 6);
        chk("sb_drained", sbq.size(), 0);
        chk("error", error, L.exp_err);
        chk("busy_after_done", busy, 0);
        chk("aw_w_hold", prot_err, 0);
        chk("aw_w_split", split > 0, L.aw_lat != L.w_lat);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        tab[0] = '{72'hAA_01234567_89ABCDEF, {32'h000000AA, 32'h01234567, 32'h89ABCDEF}};
        tab[1] = '{72'hBB_FEDCBA98_76543210, {32'h000000BB, 32'hFEDCBA98, 32'h76543210}};
        tab[2] = '{72'h00_FFFFFFFF_00000000, {32'h00000000, 32'hFFFFFFFF, 32'h00000000}};
        tab[3] = '{72'hFF_A5A5A5A5_5A5A5A5A, {32'h000000FF, 32'hA5A5A5A5, 32'h5A5A5A5A}};
        //          ia ib awl wl berr starve err
        loads[0] = '{0, 1, 0, 0, -1, 0,  1'b0};
        loads[1] = '{2, 3, 0, 3, -1, 0,  1'b0};
        loads[2] = '{1, 0, 3, 0, -1, 0,  1'b0};
        loads[3] = '{3, 2, 0, 0,  1, 0,  1'b1};
        loads[4] = '{0, 3, 0, 0, -1, 0,  1'b0};
        loads[5] = '{1, 2, 1, 2, -1, 10, 1'b0};

        aresetn = 0; start = 0; s_axis_tvalid = 0; s_axis_tdata = '0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("awprot", awprot, 0);
        chk("arprot", arprot, 0);
        chk("wstrb", wstrb, 4'hF);
        aresetn = 1;
        @(negedge aclk);
        chk("idle_tready", s_axis_tready, 0);

        for (int i = 0; i < 6; i++) run_load(loads[i]);

        // Reset while a write is waiting for awready.
        aw_lat = 6; w_lat = 6; berr = -1;
        start = 1; @(negedge aclk); start = 0;
        send_entry(0, 0);
        chk("awvalid_in_wr", awvalid, 1);
        #2 aresetn = 0;
        #1;
        chk("arst_awvalid", awvalid, 0);
        chk("arst_wvalid", wvalid, 0);
        chk("arst_busy", busy, 0);
        sbq.delete();
        @(negedge aclk); @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        run_load(loads[0]);

`ifdef LOADER_READBACK_EN
        corrupt = 1'b1;
        run_load('{2, 1, 0, 0, -1, 0, 1'b1});
        corrupt = 1'b0;
        run_load(loads[0]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
